// File: rtl/core_mem_responder.sv
// core_mem_responder
//   Memory-side responder for the core's instruction-fetch and data ports.
//   Both ports share one single-ported array of 2**ADDR_BITS 32-bit words.
//   Only one access is in flight at a time. Data requests win arbitration.
//   Each accepted request is answered exactly LATENCY cycles after acceptance
//   with a one-cycle resp pulse and registered read data.
//
// Parameters
//   ADDR_BITS  word-index width (array depth 2**ADDR_BITS)
//   LATENCY    request-accept to resp cycles, 1..15
//
// Ports
//   clk                clock, rising edge
//   rst                synchronous active-low reset
//   instr_read         fetch request, held until instr_mem_resp
//   instr_mem_address  fetch byte address
//   instr_mem_resp     one-cycle fetch-done pulse
//   instr_mem_rdata    fetched word (registered)
//   data_read          load request, held until data_mem_resp
//   data_write         store request, held until data_mem_resp
//   data_mbe           store byte enables (bit i -> byte i)
//   data_mem_address   data byte address
//   data_mem_wdata     lane-aligned store data
//   data_mem_resp      one-cycle data-done pulse
//   data_mem_rdata     loaded word, pre-write word for stores (registered)
//   err                sticky protocol error (read+write together, misaligned fetch)
module core_mem_responder #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_mem_address,
  output logic        instr_mem_resp,
  output logic [31:0] instr_mem_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  data_mbe,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  output logic        data_mem_resp,
  output logic [31:0] data_mem_rdata,
  output logic        err
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   req_data;
  logic                   req_write;
  logic [ADDR_BITS-1:0]   req_idx;
  logic [3:0]             req_mbe;
  logic [31:0]            req_wdata;

  logic [31:0]            mem [DEPTH];

  logic                   data_req;
  logic [ADDR_BITS-1:0]   data_idx;
  logic [ADDR_BITS-1:0]   instr_idx;
  logic [ADDR_BITS-1:0]   rd_idx;
  logic                   rd_data_port;
  logic                   enter_resp;
  logic [31:0]            rd_word;
  logic [31:0]            wr_mask;

  // Address bits above the index and the data byte offset do not affect
  // indexing; addresses alias modulo the array size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{instr_mem_address[31:ADDR_BITS+2],
                              data_mem_address[31:ADDR_BITS+2],
                              data_mem_address[1:0]};

  // With LATENCY=1 the array is read on the capture edge itself, so the
  // index comes straight from the ports rather than the request registers.
  always_comb begin
    data_req     = data_read | data_write;
    data_idx     = data_mem_address[ADDR_BITS+1:2];
    instr_idx    = instr_mem_address[ADDR_BITS+1:2];
    rd_idx       = req_idx;
    rd_data_port = req_data;
    enter_resp   = 1'b0;
    unique case (state)
      IDLE: begin
        rd_idx       = data_req ? data_idx : instr_idx;
        rd_data_port = data_req;
        enter_resp   = (LATENCY == 1) && (data_req || instr_read);
      end
      WAIT:    enter_resp = (cnt == '0);
      default: ;
    endcase
    rd_word = mem[rd_idx];
    wr_mask = {{8{req_mbe[3]}}, {8{req_mbe[2]}}, {8{req_mbe[1]}}, {8{req_mbe[0]}}};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      req_data        <= 1'b0;
      req_write       <= 1'b0;
      req_idx         <= '0;
      req_mbe         <= '0;
      req_wdata       <= '0;
      instr_mem_resp  <= 1'b0;
      instr_mem_rdata <= '0;
      data_mem_resp   <= 1'b0;
      data_mem_rdata  <= '0;
      err             <= 1'b0;
    end else begin
      instr_mem_resp <= 1'b0;
      data_mem_resp  <= 1'b0;

      if (enter_resp) begin
        if (rd_data_port) begin
          data_mem_resp  <= 1'b1;
          data_mem_rdata <= rd_word;
        end else begin
          instr_mem_resp  <= 1'b1;
          instr_mem_rdata <= rd_word;
        end
      end

      unique case (state)
        IDLE: begin
          if (data_req) begin
            req_data  <= 1'b1;
            req_write <= data_write;
            req_idx   <= data_idx;
            req_mbe   <= data_mbe;
            req_wdata <= data_mem_wdata;
            if (data_read && data_write) err <= 1'b1;
          end else if (instr_read) begin
            req_data  <= 1'b0;
            req_write <= 1'b0;
            req_idx   <= instr_idx;
            if (instr_mem_address[1:0] != 2'b00) err <= 1'b1;
          end
          if (data_req || instr_read) begin
            state <= (LATENCY == 1) ? RESP : WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt == '0) state <= RESP;
          else           cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Store commits on the RESP->IDLE edge, after the pre-write word was
  // returned; a reset on that edge drops the store.
  always_ff @(posedge clk) begin
    if (rst && state == RESP && req_data && req_write) begin
      mem[req_idx] <= (mem[req_idx] & ~wr_mask) | (req_wdata & wr_mask);
    end
  end

endmodule
